// File: rtl/bcd_add_serial.sv
// bcd_add_serial
//   Digit-serial packed-BCD adder/subtractor. One BCD digit is processed per
//   clock, least-significant digit first. Operands enter through a
//   valid/ready handshake. The result is held in DONE until the consumer
//   accepts it.
//
// Parameters
//   DIGITS  BCD digits per operand/result (1..16)
//   CNT_W   digit counter width, 2**CNT_W >= DIGITS
//
// Ports
//   in_clk        clock, rising edge
//   in_rst_n      asynchronous active-low reset
//   in_valid      operand set valid
//   out_ready     block can accept operands (IDLE only)
//   in_a, in_b    packed BCD operands
//   in_cin        add: carry-in, sub: borrow-in
//   in_sub        0: A+B+cin, 1: A-B-bin
//   out_valid     result valid, held until in_res_ready
//   in_res_ready  consumer accepts result
//   out_x         packed BCD result (all 4'hF digits when out_err)
//   out_cout      add: decimal carry-out, sub: 1 = no borrow
//   out_err       an input digit was > 9 (sticky for the operation)
module bcd_add_serial #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 4
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [4*DIGITS-1:0]   in_a,
  input  logic [4*DIGITS-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  in_res_ready,
  output logic [4*DIGITS-1:0]   out_x,
  output logic                  out_cout,
  output logic                  out_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             sub_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     x_q;
  logic             cout_q;
  logic             err_q;
  logic             valid_q;
  logic             ready_q;

  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [3:0] b_eff;
  logic [4:0] sum;
  logic       dig_bad;
  logic       err_next;

  // Digit select is a compare-mux over constant slices so the counter never
  // drives a variable-width part-select.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    // Subtraction adds the nine's complement; the initial carry of ~bin
    // completes the ten's complement.
    b_eff    = sub_q ? (4'd9 - b_dig) : b_dig;
    sum      = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry};
    if (sum > 5'd9) begin
      sum = sum + 5'd6;
    end
    dig_bad  = (a_dig > 4'd9) || (b_dig > 4'd9);
    err_next = err_q | dig_bad;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry   <= 1'b0;
      cnt     <= '0;
      x_q     <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            sub_q   <= in_sub;
            carry   <= in_sub ? ~in_cin : in_cin;
            cnt     <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cnt == CNT_W'(i)) begin
              x_q[4*i +: 4] <= sum[3:0];
            end
          end
          carry <= sum[4];
          err_q <= err_next;
          if (cnt == LAST) begin
            valid_q <= 1'b1;
            state   <= S_DONE;
            // Error forcing is applied on entry to DONE so the held result
            // is already the forced pattern; this overrides the digit write.
            if (err_next) begin
              x_q    <= '1;
              cout_q <= 1'b1;
            end else begin
              cout_q <= sum[4];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (in_res_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign out_ready = ready_q;
  assign out_valid = valid_q;
  assign out_x     = x_q;
  assign out_cout  = cout_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_add_serial.sv
module tb_bcd_add_serial;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         in_res_ready = 1'b0;
  logic [W-1:0] out_x;
  logic         out_cout;
  logic         out_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_add_serial #(.DIGITS(D), .CNT_W(4)) dut (
    .in_clk       (clk),
    .in_rst_n     (rst_n),
    .in_valid     (in_valid),
    .out_ready    (out_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_cin       (in_cin),
    .in_sub       (in_sub),
    .out_valid    (out_valid),
    .in_res_ready (in_res_ready),
    .out_x        (out_x),
    .out_cout     (out_cout),
    .out_err      (out_err)
  );

  // Reference: decode to integers, do decimal arithmetic, re-encode.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic sub,
                                    output logic [W-1:0] x, output logic cout,
                                    output logic err);
    longint va = 0;
    longint vb = 0;
    longint m = 1;
    longint r;
    bit bad = 0;
    for (int i = D - 1; i >= 0; i--) begin
      int da = int'(a[4*i +: 4]);
      int db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) bad = 1;
      va = va * 10 + da;
      vb = vb * 10 + db;
      m = m * 10;
    end
    if (bad) begin
      x = '1; cout = 1'b1; err = 1'b1;
      return;
    end
    if (!sub) begin
      r = va + vb + longint'(cin);
      cout = (r >= m);
      r = r % m;
    end else begin
      r = va - vb - longint'(cin);
      cout = (r >= 0);
      if (r < 0) r = r + m;
    end
    x = '0;
    for (int i = 0; i < D; i++) begin
      x[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    err = 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
    logic [W-1:0] v;
    int k;
    v = '0;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 7) == 0) begin
      k = int'($urandom_range(0, D - 1));
      v[4*k +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  // Drives one full handshake; starts and ends 1 time unit after a rising edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        output logic [W-1:0] x, output logic cout,
                        output logic err, output int lat);
    int t = 0;
    while (!out_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!out_ready) begin
      x = 'x; cout = 1'bx; err = 1'bx; lat = -1;
      return;
    end
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    in_cin = 1'($urandom); in_sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    x = out_x; cout = out_cout; err = out_err;
    in_res_ready = 1'b1;
    @(posedge clk); #1;
    in_res_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (out_x !== '0) begin failures++; $display("FAIL reset_x got=%h exp=%h", out_x, 16'h0); end
    checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", out_cout); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", out_err); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", out_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  localparam logic [W-1:0] DA [5] = '{16'h1234, 16'h9999, 16'h9999, 16'h5000, 16'h0000};
  localparam logic [W-1:0] DB [5] = '{16'h5678, 16'h0001, 16'h9999, 16'h1234, 16'h0001};
  localparam logic         DC [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic         DS [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [W-1:0] DX [5] = '{16'h6912, 16'h0000, 16'h9999, 16'h3766, 16'h9999};
  localparam logic         DO [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic test_directed;
    logic [W-1:0] x; logic c, e; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(DA[i], DB[i], DC[i], DS[i], x, c, e, lat);
      checks++; if (x !== DX[i]) begin failures++; $display("FAIL directed%0d_x got=%h exp=%h", i, x, DX[i]); end
      checks++; if (c !== DO[i]) begin failures++; $display("FAIL directed%0d_cout got=%b exp=%b", i, c, DO[i]); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL directed%0d_err got=%b exp=0", i, e); end
      checks++; if (lat !== D) begin failures++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, D); end
    end
  endtask

  task automatic test_err;
    logic [W-1:0] x; logic c, e; int lat;
    run_op(16'h12A4, 16'h0000, 1'b0, 1'b0, x, c, e, lat);
    checks++; if (x !== 16'hFFFF) begin failures++; $display("FAIL err_a_x got=%h exp=ffff", x); end
    checks++; if (c !== 1'b1) begin failures++; $display("FAIL err_a_cout got=%b exp=1", c); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL err_a_err got=%b exp=1", e); end
    run_op(16'h1111, 16'h00B0, 1'b0, 1'b1, x, c, e, lat);
    checks++; if (x !== 16'hFFFF) begin failures++; $display("FAIL err_b_x got=%h exp=ffff", x); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL err_b_err got=%b exp=1", e); end
    run_op(16'h4321, 16'h1111, 1'b0, 1'b0, x, c, e, lat);
    checks++; if (x !== 16'h5432) begin failures++; $display("FAIL err_clear_x got=%h exp=5432", x); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL err_clear_cout got=%b exp=0", c); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL err_clear_err got=%b exp=0", e); end
  endtask

  task automatic test_hold;
    int t = 0;
    in_a = 16'h2222; in_b = 16'h3333; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
    checks++; if (t !== D) begin failures++; $display("FAIL hold_latency got=%0d exp=%0d", t, D); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = rand_bcd(0); in_b = rand_bcd(0); in_sub = 1'($urandom);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid%0d got=%b exp=1", i, out_valid); end
      checks++; if (out_x !== 16'h5555) begin failures++; $display("FAIL hold_x%0d got=%h exp=5555", i, out_x); end
      checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL hold_ready%0d got=%b exp=0", i, out_ready); end
      checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL hold_cout%0d got=%b exp=0", i, out_cout); end
    end
    in_valid = 1'b0; in_res_ready = 1'b1;
    @(posedge clk); #1;
    in_res_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b exp=0", out_valid); end
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL hold_release_ready got=%b exp=1", out_ready); end
    checks++; if (out_x !== 16'h5555) begin failures++; $display("FAIL hold_idle_x got=%h exp=5555", out_x); end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] x, ex; logic c, e, ec, ee; int lat; int seen = 0;
    in_a = 16'h8888; in_b = 16'h1111; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_x[3:0] !== 4'h9) begin failures++; $display("FAIL midrun_partial got=%h exp=9", out_x[3:0]); end
    rst_n = 1'b0; #1;
    checks++; if (out_x !== '0) begin failures++; $display("FAIL midrun_rst_x got=%h exp=0000", out_x); end
    checks++; if (out_cout !== 1'b0) begin failures++; $display("FAIL midrun_rst_cout got=%b exp=0", out_cout); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL midrun_rst_err got=%b exp=0", out_err); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrun_rst_valid got=%b exp=0", out_valid); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrun_no_emit got=%0d exp=0", seen); end
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, x, c, e, lat);
    ref_model(16'h1234, 16'h4321, 1'b0, 1'b1, ex, ec, ee);
    checks++; if (x !== ex) begin failures++; $display("FAIL midrun_after_x got=%h exp=%h", x, ex); end
    checks++; if (c !== ec) begin failures++; $display("FAIL midrun_after_cout got=%b exp=%b", c, ec); end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, x, ex; logic cin, sub, c, e, ec, ee; int lat;
    for (int i = 0; i < 60; i++) begin
      a = rand_bcd(1); b = rand_bcd(1); cin = 1'($urandom); sub = 1'($urandom);
      if (i % 10 == 0) a = 16'h9999;
      if (i % 10 == 5) b = 16'h9999;
      run_op(a, b, cin, sub, x, c, e, lat);
      ref_model(a, b, cin, sub, ex, ec, ee);
      checks++; if (x !== ex || c !== ec || e !== ee || lat !== D) begin
        failures++;
        $display("FAIL random%0d a=%h b=%h cin=%b sub=%b got x=%h c=%b e=%b lat=%0d exp x=%h c=%b e=%b lat=%0d",
                 i, a, b, cin, sub, x, c, e, lat, ex, ec, ee, D);
      end
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 4;
    logic [W-1:0] oa [N]; logic [W-1:0] ob [N]; logic oc [N]; logic os [N];
    logic [W-1:0] qx [$]; logic qc [$];
    logic [W-1:0] ex; logic ec, ee, acc;
    int j = 0; int got = 0; int last_cyc = -1;
    for (int i = 0; i < N; i++) begin
      oa[i] = rand_bcd(0); ob[i] = rand_bcd(0); oc[i] = 1'($urandom); os[i] = 1'($urandom);
    end
    in_res_ready = 1'b1;
    in_a = oa[0]; in_b = ob[0]; in_cin = oc[0]; in_sub = os[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 100 && got < N; cyc++) begin
      acc = out_ready && in_valid;
      @(posedge clk); #1;
      if (acc) begin
        ref_model(oa[j], ob[j], oc[j], os[j], ex, ec, ee);
        qx.push_back(ex); qc.push_back(ec);
        j++;
        if (j < N) begin
          in_a = oa[j]; in_b = ob[j]; in_cin = oc[j]; in_sub = os[j];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && qx.size() > 0) begin
        ex = qx.pop_front(); ec = qc.pop_front();
        checks++; if (out_x !== ex || out_cout !== ec) begin
          failures++; $display("FAIL b2b_result%0d got x=%h c=%b exp x=%h c=%b", got, out_x, out_cout, ex, ec);
        end
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc !== D + 2) begin
            failures++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", got, cyc - last_cyc, D + 2);
          end
        end
        last_cyc = cyc;
        got++;
      end
    end
    in_valid = 1'b0; in_res_ready = 1'b0;
    checks++; if (got !== N) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got, N); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_err;
    test_hold;
    test_reset_mid_run;
    test_random;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
